// File: rtl/scan_ctrl_pkg.sv
// Shared types and helpers for the scan chain controller.
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Width of a down-counter that must hold values up to depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return unsigned'($clog2(depth + 1));
  endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Left-shifting register with parallel load; serial out is the MSB.
module scan_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout
);

  // Parallel load wins over shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], sin};
    end
  end

  assign sout = q[WIDTH-1];

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: serial load, functional capture, serial unload.
// Optional response compare is enabled by defining SCAN_COMPARE_EN.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned CHAIN_LEN  = 8,
  parameter int unsigned CAP_CYCLES = 1
) (
  input  logic                 CK,
  input  logic                 RN,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PATTERN,
  input  logic                 SCAN_SO,
`ifdef SCAN_COMPARE_EN
  input  logic [CHAIN_LEN-1:0] EXPECT,
  output logic                 MISMATCH,
`endif
  output logic                 SCAN_SE,
  output logic                 SCAN_SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESPONSE
);

  localparam int unsigned CW = cnt_width(CHAIN_LEN);

  state_e          state_q;
  state_e          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            cnt_last;
  logic            accept;
  logic            se_d;
  logic            busy_d;
  logic            done_d;
  logic [CHAIN_LEN-1:0] pat_unused;
  logic            resp_sout_unused;

  assign cnt_last = (cnt_q == '0);
  assign accept   = (state_q == ST_IDLE) && START;

  // Next state, counter reload on every state entry, and next output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_LOAD;
          cnt_d   = CW'(CHAIN_LEN - 1);
        end
      end
      ST_LOAD: begin
        if (cnt_last) begin
          state_d = ST_CAPTURE;
          cnt_d   = CW'(CAP_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_CAPTURE: begin
        if (cnt_last) begin
          state_d = ST_UNLOAD;
          cnt_d   = CW'(CHAIN_LEN - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_UNLOAD: begin
        if (cnt_last) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    se_d   = (state_d == ST_LOAD) || (state_d == ST_UNLOAD);
    busy_d = (state_d == ST_LOAD) || (state_d == ST_CAPTURE) || (state_d == ST_UNLOAD);
    done_d = (state_d == ST_DONE);
  end

  // State, counter and control outputs.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      SCAN_SE <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      SCAN_SE <= se_d;
      BUSY    <= busy_d;
      DONE    <= done_d;
    end
  end

  // Pattern source: MSB drives SI; zero fill leaves SI low after LOAD.
  scan_shift_reg #(
    .WIDTH (CHAIN_LEN)
  ) u_pattern (
    .clk      (CK),
    .rst_n    (RN),
    .load     (accept),
    .load_val (PATTERN),
    .shift_en (state_q == ST_LOAD),
    .sin      (1'b0),
    .q        (pat_unused),
    .sout     (SCAN_SI)
  );

  // Response sink: cleared on accept, first SO sample ends up in the MSB.
  scan_shift_reg #(
    .WIDTH (CHAIN_LEN)
  ) u_response (
    .clk      (CK),
    .rst_n    (RN),
    .load     (accept),
    .load_val ('0),
    .shift_en (state_q == ST_UNLOAD),
    .sin      (SCAN_SO),
    .q        (RESPONSE),
    .sout     (resp_sout_unused)
  );

`ifdef SCAN_COMPARE_EN
  logic [CHAIN_LEN-1:0] expect_q;
  logic [CHAIN_LEN-1:0] resp_final;

  // Final response word as it will appear on entry to DONE.
  assign resp_final = {RESPONSE[CHAIN_LEN-2:0], SCAN_SO};

  // Latch expected word on accept; flag differences on entry to DONE.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      expect_q <= '0;
      MISMATCH <= 1'b0;
    end else if (accept) begin
      expect_q <= EXPECT;
      MISMATCH <= 1'b0;
    end else if ((state_q == ST_UNLOAD) && cnt_last) begin
      MISMATCH <= |(resp_final ^ expect_q);
    end
  end
`endif

endmodule
